// File: rtl/gcm_pkg.sv
// Shared constants and the output beat layout for the GCM ciphertext assembler.
package gcm_pkg;

  localparam int BLOCK_W      = 128;
  localparam int LEN_W        = 64;
  localparam int BYPASS_DEPTH = 15;

  typedef struct packed {
    logic [0:BLOCK_W-1] data;
    logic [0:BLOCK_W-1] user;
    logic [0:BLOCK_W-1] keep;
    logic               last;
  } beat_t;

endpackage

// File: rtl/gcm_sync_fifo.sv
// Single-clock FIFO with combinational read port; a push while full is accepted
// only when a pop happens on the same edge.
module gcm_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_d, wr_ptr_q;
  logic [AW-1:0]    rd_ptr_d, rd_ptr_q;
  logic [AW:0]      count_d, count_q;
  logic             push_ok, pop_ok;

  assign o_full  = (count_q == FULL_CNT);
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_data  = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = i_pop & ~o_empty;
    push_ok  = i_push & (~o_full | pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

// File: rtl/gcm_ct_assembler.sv
// Masks keystream against bypassed plaintext, buffers ciphertext beats for an
// AXI-Stream consumer and produces the GCM len(A)||len(C) block per packet.
module gcm_ct_assembler
  import gcm_pkg::*;
#(
  parameter int DEPTH     = 32,
  parameter int AFULL_LVL = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  input  logic [0:BLOCK_W-1]   i_keystream,
  input  logic [0:BLOCK_W-1]   i_text,
  input  logic [0:BLOCK_W-1]   i_tuser,
  input  logic [0:BLOCK_W-1]   i_tkeep,
  input  logic                 i_tlast,
  input  logic [0:LEN_W-1]     i_aad_bits,
  output logic [0:BLOCK_W-1]   o_tdata,
  output logic [0:BLOCK_W-1]   o_tuser,
  output logic [0:BLOCK_W-1]   o_tkeep,
  output logic                 o_tlast,
  output logic                 o_tvalid,
  input  logic                 i_tready,
  output logic                 o_len_valid,
  output logic [0:BLOCK_W-1]   o_len_block,
  output logic                 o_afull,
  output logic                 o_overflow
);

  localparam int CW        = $clog2(DEPTH) + 1;
  // Threshold is clamped so upstream still has room for blocks already in the bypass chain.
  localparam int AFULL_EFF = (AFULL_LVL > DEPTH - BYPASS_DEPTH) ? DEPTH - BYPASS_DEPTH : AFULL_LVL;
  localparam logic [CW-1:0] AFULL_THR = CW'(AFULL_EFF);

  function automatic logic [LEN_W-1:0] popcount(input logic [0:BLOCK_W-1] v);
    logic [LEN_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < BLOCK_W; i++) cnt = cnt + {{(LEN_W-1){1'b0}}, v[i]};
    return cnt;
  endfunction

  beat_t              beat_p1_d, beat_p1_q, out_beat;
  logic               vld_p1_d, vld_p1_q;
  logic [LEN_W-1:0]   len_sum_p1_d, len_sum_p1_q;
  logic [0:LEN_W-1]   aad_p1_d, aad_p1_q;
  logic [LEN_W-1:0]   cnt_d, cnt_q;
  logic               len_valid_d, len_valid_q;
  logic [0:BLOCK_W-1] len_block_d, len_block_q;
  logic               overflow_d, overflow_q;
  logic               fifo_full, fifo_empty, pop;
  logic [CW-1:0]      fifo_count;

  // Stage p1: mask, side-band capture and running ciphertext bit count
  always_comb begin
    vld_p1_d       = i_valid;
    beat_p1_d.data = (i_keystream ^ i_text) & i_tkeep;
    beat_p1_d.user = i_tuser;
    beat_p1_d.keep = i_tkeep;
    beat_p1_d.last = i_tlast;
    len_sum_p1_d   = cnt_q + popcount(i_tkeep);
    aad_p1_d       = i_aad_bits;
    cnt_d          = cnt_q;
    if (i_valid) cnt_d = i_tlast ? '0 : len_sum_p1_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    beat_p1_q    <= beat_p1_d;
    len_sum_p1_q <= len_sum_p1_d;
    aad_p1_q     <= aad_p1_d;
  end

  // Stage p2: FIFO write, length block publish, overflow tracking
  assign pop = o_tvalid & i_tready;

  always_comb begin
    len_valid_d = vld_p1_q & beat_p1_q.last;
    len_block_d = len_valid_d ? {aad_p1_q, len_sum_p1_q} : len_block_q;
    overflow_d  = overflow_q | (vld_p1_q & fifo_full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_valid_q <= 1'b0;
      len_block_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      len_valid_q <= len_valid_d;
      len_block_q <= len_block_d;
      overflow_q  <= overflow_d;
    end
  end

  gcm_sync_fifo #(
    .WIDTH ($bits(beat_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (vld_p1_q),
    .i_data  (beat_p1_q),
    .i_pop   (pop),
    .o_data  (out_beat),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  assign o_tvalid    = ~fifo_empty;
  assign o_tdata     = out_beat.data;
  assign o_tuser     = out_beat.user;
  assign o_tkeep     = out_beat.keep;
  assign o_tlast     = out_beat.last;
  assign o_afull     = (fifo_count >= AFULL_THR);
  assign o_len_valid = len_valid_q;
  assign o_len_block = len_block_q;
  assign o_overflow  = overflow_q;

endmodule

// File: doc/gcm_ct_assembler.md
GCM_CT_ASSEMBLER -- requirements
Module: gcm_ct_assembler

Interface
REQ-001 Parameter DEPTH, default 32: output FIFO entries; power of two, at least 16.
REQ-002 Parameter AFULL_LVL, default 16: occupancy at or above which o_afull asserts; must be at most DEPTH-15.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 rst_n  in  1  reset; synchronous, active-low.
REQ-005 i_valid  in  1  keystream and bypassed side-band valid this cycle; no stall path.
REQ-006 i_keystream  in  [0:127]  AES(K, counter) output of the round pipeline.
REQ-007 i_text  in  [0:127]  plaintext delayed through the text bypass chain.
REQ-008 i_tuser  in  [0:127]  AAD side-band, delayed with i_text.
REQ-009 i_tkeep  in  [0:127]  bit mask, 1 = bit valid; contiguous from bit 0, multiple of 8 ones.
REQ-010 i_tlast  in  1  final block of packet.
REQ-011 i_aad_bits  in  [0:63]  packet AAD length in bits; sampled with i_tlast.
REQ-012 o_tdata  out  [0:127]  masked ciphertext.
REQ-013 o_tuser / o_tkeep / o_tlast  out  [0:127]/[0:127]/1  side-band aligned to o_tdata.
REQ-014 o_tvalid  out  1 / i_tready  in  1  AXI-Stream handshake.
REQ-015 o_len_valid  out  1  one-cycle pulse; o_len_block valid.
REQ-016 o_len_block  out  [0:127]  len(A)||len(C) in bits, bits 0..63 AAD, 64..127 ciphertext.
REQ-017 o_afull  out  1  upstream credit stop; o_overflow  out  1  sticky error.

Function
REQ-018 Each i_valid cycle: ct = (i_keystream XOR i_text) AND i_tkeep, registered (1-cycle stage) with i_tuser, i_tkeep, i_tlast.
REQ-019 Registered stage writes into a DEPTH-entry FIFO the cycle after i_valid; input-to-o_tvalid latency 2 cycles when the FIFO is empty.
REQ-020 o_tvalid = FIFO not empty; pop on o_tvalid AND i_tready; o_t* stable while o_tvalid high and i_tready low.
REQ-021 Simultaneous push and pop at full: both succeed, occupancy unchanged; at empty: push only, no bypass.
REQ-022 Push while full without pop: entry dropped, o_overflow set until reset, occupancy unchanged.
REQ-023 o_afull = occupancy >= AFULL_LVL, combinational from registered occupancy.
REQ-024 Pointers wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
REQ-025 Length accumulator: on each accepted input block add popcount(i_tkeep) to 64-bit C-bit counter; wraps modulo 2^64.
REQ-026 On accepted i_tlast: o_len_block = {i_aad_bits, counter including this block}, o_len_valid pulses 2 cycles after i_valid, counter clears to 0 same edge.
REQ-027 Back-to-back packets (tlast then new block next cycle): new block counts from 0; no lost cycle.
REQ-028 i_valid low: no push, no counter change; i_tkeep all-zero with i_valid: pushes zero block, adds 0.

Reset
REQ-029 rst_n low at a clock edge: FIFO empty, pointers 0, counter 0, o_tvalid 0, o_len_valid 0, o_len_block 0, o_overflow 0, o_afull 0, pipeline stage invalid.
REQ-030 Reset mid-packet discards buffered and in-flight data; first block after release starts a new packet.

Structure
REQ-031 Shared package gcm_pkg holds BLOCK_W=128, LEN_W=64, BYPASS_DEPTH=15 and the output beat struct (data, user, keep, last).
REQ-032 One sub-module: gcm_sync_fifo (parameterised width/depth, full/empty/count) instantiated once; popcount and XOR/mask inline.

Verification
REQ-033 Single block, keystream 0xFF..FF, text 0x00..00, tkeep all ones, tlast=1, aad_bits=128, i_tready=1 -> o_tdata 0xFF..FF two cycles later, o_len_block {64'd128, 64'd128}, one o_len_valid pulse.
REQ-034 Partial block tkeep = 40 leading ones, keystream all ones -> o_tdata bits 0..39 = NOT text, 40..127 zero; len(C) adds 40.
REQ-035 i_tready low, 16 consecutive blocks -> o_afull high after the 16th write, 16 beats drained in order on i_tready high, o_overflow 0.
REQ-036 i_tready low, 33 blocks into DEPTH=32 -> 33rd dropped, o_overflow 1 sticky, first 32 beats intact.
REQ-037 Packet of 3 full blocks, tlast, immediately followed by 1-block packet of 8 bits -> len(C) 384 then 8.
REQ-038 Assert rst_n low with 5 beats buffered -> o_tvalid 0 next cycle, counter 0, next packet length counted from 0.
